mips_trace_buffer: RTL and testbench

//  Hardware retired-instruction trace capture, downstream of the CPU commit point.

---
 rtl/mips_trace_buffer_pkg.sv | 30 +++
 rtl/mips_trace_buffer_if.sv | 38 +++
 rtl/mips_trace_buffer_trace_ram.sv | 32 +++
 rtl/mips_trace_buffer.sv | 115 +++++++++++
 tb/tb_mips_trace_buffer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_trace_buffer_pkg.sv
// Shared types for the retired-instruction trace buffer: FSM states, record layout, NOP encoding.
// Build option: define TRACE_MEM_EN to add the store-port fields to every record.
package mips_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_POST   = 2'd2,
        ST_FROZEN = 2'd3
    } trace_state_t;

    localparam logic [31:0] NOP = 32'h0000_0000;

    // Field order matches the readout word, most significant field first.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        reg_we;
        logic [4:0]  reg_addr;
        logic [31:0] reg_data;
`ifdef TRACE_MEM_EN
        logic        mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_data;
`endif
    } trace_rec_t;

    localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/mips_trace_buffer_if.sv
// Commit-view, control and readout bundle between the CPU side / debug port and the trace buffer.
interface mips_trace_buffer_if
    import mips_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic             en;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic             reg_we;
    logic [4:0]       reg_addr;
    logic [31:0]      reg_data;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             arm;
    logic             trig;
    logic             rd_req;
    logic             rd_valid;
    logic [REC_W-1:0] rd_data;
    logic [AW:0]      count;
    logic [1:0]       state;

    modport master (
        output en, pc, instr, reg_we, reg_addr, reg_data,
        output mem_we, mem_addr, mem_data, arm, trig, rd_req,
        input  rd_valid, rd_data, count, state
    );

    modport slave (
        input  en, pc, instr, reg_we, reg_addr, reg_data,
        input  mem_we, mem_addr, mem_data, arm, trig, rd_req,
        output rd_valid, rd_data, count, state
    );

endinterface

// File: rtl/mips_trace_buffer_trace_ram.sv
// Simple dual-port record store: one write port, one registered read port.
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    // Array has no reset so it maps onto block RAM; old contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// Retired-instruction trace buffer: circular capture, trigger + post-trigger freeze, oldest-first drain.
// Build option: TRACE_MEM_EN adds mem_we/mem_addr/mem_data to each record.
module mips_trace_buffer
    import mips_trace_buffer_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter bit SKIP_NOP  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    mips_trace_buffer_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    trace_state_t     state_q;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    post_cnt;
    logic [AW:0]      count_q;
    logic             rd_valid_q;
    logic             is_nop;
    logic             cap_evt;
    logic             wr_en;
    logic             rd_en;
    logic [REC_W-1:0] wr_rec;

    assign is_nop  = SKIP_NOP && (bus.instr == NOP);
    assign cap_evt = bus.en && (state_q == ST_ARMED || state_q == ST_POST) && !is_nop;
    // arm wins over everything else in its cycle, including a capture or a pop.
    assign wr_en   = cap_evt && !bus.arm;
    assign rd_en   = (state_q == ST_FROZEN) && bus.rd_req && (count_q != '0) && !bus.arm;

`ifdef TRACE_MEM_EN
    assign wr_rec = {bus.pc, bus.instr, bus.reg_we, bus.reg_addr, bus.reg_data,
                     bus.mem_we, bus.mem_addr, bus.mem_data};
`else
    logic unused_mem;
    assign unused_mem = ^{bus.mem_we, bus.mem_addr, bus.mem_data};
    assign wr_rec     = {bus.pc, bus.instr, bus.reg_we, bus.reg_addr, bus.reg_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            post_cnt   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (bus.arm) begin
                state_q  <= ST_ARMED;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                post_cnt <= '0;
                count_q  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    if (count_q == (AW+1)'(DEPTH)) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    count_q <= count_q - 1'b1;
                end
                case (state_q)
                    ST_ARMED: begin
                        if (cap_evt && bus.trig) begin
                            if (POST_TRIG == 0) begin
                                state_q <= ST_FROZEN;
                            end else begin
                                post_cnt <= AW'(POST_TRIG);
                                state_q  <= ST_POST;
                            end
                        end
                    end
                    ST_POST: begin
                        if (cap_evt) begin
                            post_cnt <= post_cnt - 1'b1;
                            if (post_cnt == AW'(1)) begin
                                state_q <= ST_FROZEN;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wr_rec),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (bus.rd_data)
    );

    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: a 64-deep/16-post instance and an 8-deep/0-post instance.
module tb_mips_trace_buffer;
    import mips_trace_buffer_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [REC_W-1:0] q_a[$];
    logic [REC_W-1:0] q_b[$];

    mips_trace_buffer_if #(.DEPTH(64)) bus_a ();
    mips_trace_buffer_if #(.DEPTH(8))  bus_b ();

    mips_trace_buffer #(.DEPTH(64), .POST_TRIG(16), .SKIP_NOP(1'b1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mips_trace_buffer #(.DEPTH(8), .POST_TRIG(0), .SKIP_NOP(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] pc, input logic [31:0] instr,
                                                input logic we, input logic [4:0] ra,
                                                input logic [31:0] rd);
`ifdef TRACE_MEM_EN
        return {pc, instr, we, ra, rd, 65'b0};
`else
        return {pc, instr, we, ra, rd};
`endif
    endfunction

    // Record produced by commit number i of the long wrap-around run.
    function automatic logic [REC_W-1:0] mk_rec_i(input int i);
        logic [31:0] iv;
        iv = 32'(i);
        return mk_rec(iv * 32'd4, 32'h2008_0000 + iv, iv[0], iv[4:0], iv * 32'd3);
    endfunction

    task automatic idle_all();
        bus_a.en = 1'b0; bus_a.pc = '0; bus_a.instr = '0; bus_a.reg_we = 1'b0;
        bus_a.reg_addr = '0; bus_a.reg_data = '0; bus_a.mem_we = 1'b0; bus_a.mem_addr = '0;
        bus_a.mem_data = '0; bus_a.arm = 1'b0; bus_a.trig = 1'b0; bus_a.rd_req = 1'b0;
        bus_b.en = 1'b0; bus_b.pc = '0; bus_b.instr = '0; bus_b.reg_we = 1'b0;
        bus_b.reg_addr = '0; bus_b.reg_data = '0; bus_b.mem_we = 1'b0; bus_b.mem_addr = '0;
        bus_b.mem_data = '0; bus_b.arm = 1'b0; bus_b.trig = 1'b0; bus_b.rd_req = 1'b0;
    endtask

    // Drives one cycle on the chosen instance, then returns 1 time unit after the edge.
    task automatic apply_stimulus(input bit sel_b, input logic en, input logic [31:0] pc,
                                  input logic [31:0] instr, input logic we, input logic [4:0] ra,
                                  input logic [31:0] rd, input logic mwe, input logic [31:0] ma,
                                  input logic [31:0] md, input logic trig, input logic arm,
                                  input logic rd_req);
        if (sel_b) begin
            bus_b.en = en; bus_b.pc = pc; bus_b.instr = instr; bus_b.reg_we = we;
            bus_b.reg_addr = ra; bus_b.reg_data = rd; bus_b.mem_we = mwe; bus_b.mem_addr = ma;
            bus_b.mem_data = md; bus_b.trig = trig; bus_b.arm = arm; bus_b.rd_req = rd_req;
        end else begin
            bus_a.en = en; bus_a.pc = pc; bus_a.instr = instr; bus_a.reg_we = we;
            bus_a.reg_addr = ra; bus_a.reg_data = rd; bus_a.mem_we = mwe; bus_a.mem_addr = ma;
            bus_a.mem_data = md; bus_a.trig = trig; bus_a.arm = arm; bus_a.rd_req = rd_req;
        end
        @(posedge clk);
        #1;
        idle_all();
    endtask

    task automatic commit_rec(input bit sel_b, input logic [31:0] pc, input logic [31:0] instr,
                              input logic we, input logic [4:0] ra, input logic [31:0] rd,
                              input logic trig);
        apply_stimulus(sel_b, 1'b1, pc, instr, we, ra, rd, 1'b0, '0, '0, trig, 1'b0, 1'b0);
    endtask

    task automatic pulse_arm(input bit sel_b);
        apply_stimulus(sel_b, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic pulse_read(input bit sel_b);
        apply_stimulus(sel_b, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic monitor_a();
        logic [REC_W-1:0] exp_rec;
        forever begin
            @(negedge clk);
            if (bus_a.rd_valid === 1'b1) begin
                total++;
                if (q_a.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL a_unexpected_rd_valid: got rd_data 0x%0h want no record", bus_a.rd_data);
                end else begin
                    exp_rec = q_a.pop_front();
                    if (bus_a.rd_data !== exp_rec) begin
                        bad++;
                        $display("[TB] FAIL a_rd_data: got 0x%0h want 0x%0h", bus_a.rd_data, exp_rec);
                    end
                end
            end
        end
    endtask

    task automatic monitor_b();
        logic [REC_W-1:0] exp_rec;
        forever begin
            @(negedge clk);
            if (bus_b.rd_valid === 1'b1) begin
                total++;
                if (q_b.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL b_unexpected_rd_valid: got rd_data 0x%0h want no record", bus_b.rd_data);
                end else begin
                    exp_rec = q_b.pop_front();
                    if (bus_b.rd_data !== exp_rec) begin
                        bad++;
                        $display("[TB] FAIL b_rd_data: got 0x%0h want 0x%0h", bus_b.rd_data, exp_rec);
                    end
                end
            end
        end
    endtask

    initial begin
        logic [REC_W-1:0] mem_rec;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_all();
        fork
            monitor_a();
            monitor_b();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_state", 32'(bus_a.state), 32'd0);
        check_output("reset_count", 32'(bus_a.count), 32'd0);
        check_output("reset_rd_valid", 32'(bus_a.rd_valid), 32'd0);
        check_output("reset_rd_data_pc", bus_a.rd_data[REC_W-1 -: 32], 32'd0);
        rst = 1'b0;

        // Capture without trigger stays ARMED.
        pulse_arm(1'b0);
        check_output("arm_state", 32'(bus_a.state), 32'd1);
        for (int i = 0; i < 10; i++) begin
            commit_rec(1'b0, 32'(4 * i), 32'h2008_0000 + 32'(i), 1'b1, 5'd8, 32'(i), 1'b0);
        end
        check_output("ten_commits_count", 32'(bus_a.count), 32'd10);
        check_output("ten_commits_state", 32'(bus_a.state), 32'd1);

        // Wrap-around run: trigger at i=50, freeze on i=66, oldest kept is i=3.
        pulse_arm(1'b0);
        for (int i = 0; i < 100; i++) begin
            commit_rec(1'b0, 32'(4 * i), 32'h2008_0000 + 32'(i), i[0], i[4:0], 32'(i * 3), i == 50);
            if (i == 65) check_output("post_before_last", 32'(bus_a.state), 32'd2);
            if (i == 66) check_output("frozen_at_66", 32'(bus_a.state), 32'd3);
        end
        check_output("wrap_count", 32'(bus_a.count), 32'd64);
        check_output("wrap_state", 32'(bus_a.state), 32'd3);
        for (int j = 3; j <= 66; j++) begin
            q_a.push_back(mk_rec_i(j));
            pulse_read(1'b0);
        end
        pulse_read(1'b0);
        check_output("empty_read_no_valid", 32'(bus_a.rd_valid), 32'd0);
        check_output("drained_count", 32'(bus_a.count), 32'd0);

        // NOP filtering and en gating.
        pulse_arm(1'b0);
        commit_rec(1'b0, 32'h0, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        commit_rec(1'b0, 32'h4, 32'h2008_0001, 1'b1, 5'd8, 32'd1, 1'b0);
        commit_rec(1'b0, 32'h8, NOP, 1'b0, 5'd0, 32'd0, 1'b0);
        commit_rec(1'b0, 32'hC, 32'hAC08_0000, 1'b0, 5'd0, 32'd0, 1'b0);
        check_output("skip_nop_count", 32'(bus_a.count), 32'd2);
        apply_stimulus(1'b0, 1'b0, 32'h10, 32'h2008_0002, 1'b1, 5'd8, 32'd2,
                       1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check_output("en_low_count", 32'(bus_a.count), 32'd2);

        // Zero post-trigger instance: trigger record freezes immediately.
        pulse_arm(1'b1);
        commit_rec(1'b1, 32'h40, 32'h2008_0005, 1'b1, 5'd8, 32'h5, 1'b1);
        check_output("b_post0_state", 32'(bus_b.state), 32'd3);
        check_output("b_post0_count", 32'(bus_b.count), 32'd1);
        q_b.push_back(mk_rec(32'h40, 32'h2008_0005, 1'b1, 5'd8, 32'h5));
        pulse_read(1'b1);
        check_output("b_post0_drained", 32'(bus_b.count), 32'd0);

        // arm beats trig/rd_req in FROZEN; an in-flight read still completes.
        pulse_arm(1'b1);
        for (int k = 0; k < 5; k++) begin
            commit_rec(1'b1, 32'h100 + 32'(4 * k), 32'h2009_0000 + 32'(k), 1'b1, 5'd9, 32'(k), k == 4);
        end
        check_output("b_five_state", 32'(bus_b.state), 32'd3);
        check_output("b_five_count", 32'(bus_b.count), 32'd5);
        q_b.push_back(mk_rec(32'h100, 32'h2009_0000, 1'b1, 5'd9, 32'd0));
        pulse_read(1'b1);
        apply_stimulus(1'b1, 1'b1, 32'h200, 32'h2009_0009, 1'b1, 5'd9, 32'd9,
                       1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
        check_output("b_arm_trig_state", 32'(bus_b.state), 32'd1);
        check_output("b_arm_trig_count", 32'(bus_b.count), 32'd0);

        // Store commit carries the memory port fields when they are built in.
        apply_stimulus(1'b1, 1'b1, 32'h300, 32'hAC09_0100, 1'b0, 5'd0, 32'd0,
                       1'b1, 32'h100, 32'hDEAD, 1'b1, 1'b0, 1'b0);
        check_output("b_store_state", 32'(bus_b.state), 32'd3);
`ifdef TRACE_MEM_EN
        mem_rec = {32'h300, 32'hAC09_0100, 1'b0, 5'd0, 32'd0, 1'b1, 32'h100, 32'hDEAD};
`else
        mem_rec = {32'h300, 32'hAC09_0100, 1'b0, 5'd0, 32'd0};
`endif
        q_b.push_back(mem_rec);
        pulse_read(1'b1);

        // Reset in the middle of post-trigger capture.
        pulse_arm(1'b0);
        commit_rec(1'b0, 32'h500, 32'h2008_0100, 1'b1, 5'd8, 32'd1, 1'b1);
        commit_rec(1'b0, 32'h504, 32'h2008_0101, 1'b1, 5'd8, 32'd2, 1'b0);
        check_output("post_state", 32'(bus_a.state), 32'd2);
        check_output("post_count", 32'(bus_a.count), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("rst_mid_state", 32'(bus_a.state), 32'd0);
        check_output("rst_mid_count", 32'(bus_a.count), 32'd0);

        for (int w = 0; w < 10 && (q_a.size() != 0 || q_b.size() != 0); w++) begin
            @(posedge clk);
        end
        #1;
        check_output("a_queue_empty", 32'(q_a.size()), 32'd0);
        check_output("b_queue_empty", 32'(q_b.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
